// File: rtl/regfile_mp.sv
// Multi-port integer register file: NREAD combinational read ports, two write ports
// (WP0 has priority), same-cycle bypass, and a per-register busy scoreboard.
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREAD*AW-1:0]     rs,
  output logic [NREAD*XLEN-1:0]   dataout,
  output logic [NREAD-1:0]        busy,
  input  logic                    we0,
  input  logic [AW-1:0]           rd0,
  input  logic [XLEN-1:0]         datain0,
  input  logic                    we1,
  input  logic [AW-1:0]           rd1,
  input  logic [XLEN-1:0]         datain1,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd
);

  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [XLEN-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // WP1 is applied first so a colliding WP0 write overwrites it.
  always_comb begin
    regs_d = regs_q;
    if (we1) regs_d[rd1] = datain1;
    if (we0) regs_d[rd0] = datain0;
    regs_d[0] = '0;
  end

  // Clears come before the set so a newly issued producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[rd0] = 1'b0;
    if (we1) busy_d[rd1] = 1'b0;
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    dataout = '0;
    busy    = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      logic [AW-1:0] ra;
      logic          hit0;
      logic          hit1;
      ra   = rs[i*AW +: AW];
      hit0 = we0 && (rd0 == ra);
      hit1 = we1 && (rd1 == ra);
      if (!reset && (ra != '0)) begin
        if (hit0)      dataout[i*XLEN +: XLEN] = datain0;
        else if (hit1) dataout[i*XLEN +: XLEN] = datain1;
        else           dataout[i*XLEN +: XLEN] = regs_q[ra];
        busy[i] = busy_q[ra] && !hit0 && !hit1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREAD*AW-1:0]   rs;
  logic [NREAD*XLEN-1:0] dataout;
  logic [NREAD-1:0]      busy;
  logic                  we0, we1, iss_valid;
  logic [AW-1:0]         rd0, rd1, iss_rd;
  logic [XLEN-1:0]       datain0, datain1;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
    .clock(clock), .reset(reset), .rs(rs), .dataout(dataout), .busy(busy),
    .we0(we0), .rd0(rd0), .datain0(datain0),
    .we1(we1), .rd1(rd1), .datain1(datain1),
    .iss_valid(iss_valid), .iss_rd(iss_rd)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] mem [DEPTH];
  bit              sb  [DEPTH];

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_read(input int unsigned a);
    if (reset || a == 0) return '0;
    if (we0 && rd0 == a) return datain0;
    if (we1 && rd1 == a) return datain1;
    return mem[a];
  endfunction

  function automatic logic ref_busy(input int unsigned a);
    if (reset || a == 0) return 1'b0;
    if ((we0 && rd0 == a) || (we1 && rd1 == a)) return 1'b0;
    return sb[a];
  endfunction

  task automatic check_ports(input string tag);
    for (int p = 0; p < NREAD; p++) begin
      int unsigned a;
      a = rs[p*AW +: AW];
      check($sformatf("%s.data%0d[r%0d]", tag, p, a), dataout[p*XLEN +: XLEN], ref_read(a));
      check($sformatf("%s.busy%0d[r%0d]", tag, p, a), {31'd0, busy[p]}, {31'd0, ref_busy(a)});
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < DEPTH; r++) begin
      mem[r] = '0;
      sb[r]  = 1'b0;
    end
  endtask

  // Advance one clock edge and apply that edge's writes/issues to the model.
  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      if (we1 && rd1 != 0) mem[rd1] = datain1;
      if (we0 && rd0 != 0) mem[rd0] = datain0;
      if (we0) sb[rd0] = 1'b0;
      if (we1) sb[rd1] = 1'b0;
      if (iss_valid && iss_rd != 0) sb[iss_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic set_rs_all(input logic [AW-1:0] a);
    for (int p = 0; p < NREAD; p++) rs[p*AW +: AW] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    rs = '0; rd0 = '0; rd1 = '0; iss_rd = '0; datain0 = '0; datain1 = '0;
    model_clear();
    #1 check_ports("rst_idle");
    we0 = 1'b1; rd0 = 5'd3; datain0 = 32'hDEADBEEF; iss_valid = 1'b1; iss_rd = 5'd3;
    set_rs_all(5'd3);
    #1 check_ports("rst_forced");
    check("rst_forced_const", dataout[XLEN-1:0], 32'h0);
    idle();
    #20 reset = 1'b0;

    for (int a = 0; a < DEPTH; a++) begin
      set_rs_all(a[AW-1:0]);
      #1 check_ports("t1");
    end
    @(posedge clock); #1;

    we0 = 1'b1; rd0 = 5'd1; datain0 = 32'h12345678; set_rs_all(5'd1);
    #1 check_ports("t2_bypass");
    check("t2_bypass_const", dataout[XLEN +: XLEN], 32'h12345678);
    tick(); idle();
    #1 check_ports("t2_stored");
    check("t2_stored_const", dataout[XLEN-1:0], 32'h12345678);

    we0 = 1'b1; rd0 = 5'd0; datain0 = 32'hFFFFFFFF; set_rs_all(5'd0);
    #1 check_ports("t3_bypass");
    tick(); idle();
    #1 check_ports("t3_stored");
    check("t3_r0_const", dataout[XLEN +: XLEN], 32'h0);

    we0 = 1'b1; we1 = 1'b1; rd0 = 5'd5; rd1 = 5'd5;
    datain0 = 32'hAAAA0000; datain1 = 32'h5555FFFF; set_rs_all(5'd5);
    #1 check_ports("t4_bypass");
    check("t4_bypass_const", dataout[XLEN-1:0], 32'hAAAA0000);
    tick(); idle();
    #1 check_ports("t4_stored");
    check("t4_stored_const", dataout[XLEN +: XLEN], 32'hAAAA0000);

    iss_valid = 1'b1; iss_rd = 5'd7;
    tick(); idle(); set_rs_all(5'd7);
    #1 check_ports("t5_busy");
    check("t5_busy_const", {31'd0, busy[0]}, 32'd1);
    we1 = 1'b1; rd1 = 5'd7; datain1 = 32'h00C0FFEE;
    #1 check_ports("t5_arrive");
    check("t5_arrive_busy", {31'd0, busy[1]}, 32'd0);
    check("t5_arrive_data", dataout[XLEN-1:0], 32'h00C0FFEE);
    tick(); idle();
    #1 check_ports("t5_after");
    check("t5_after_busy", {31'd0, busy[0]}, 32'd0);

    iss_valid = 1'b1; iss_rd = 5'd9; we0 = 1'b1; rd0 = 5'd9; datain0 = 32'h99999999;
    tick(); idle(); set_rs_all(5'd9);
    #1 check_ports("t6_busy");
    check("t6_busy_const", {31'd0, busy[1]}, 32'd1);
    we0 = 1'b1; rd0 = 5'd9; datain0 = 32'h13579BDF;
    reset = 1'b1; model_clear();
    #1 check_ports("t6_rst");
    check("t6_rst_data", dataout[XLEN-1:0], 32'h0);
    check("t6_rst_busy", {30'd0, busy}, 32'd0);
    idle();
    #1 reset = 1'b0;
    #1 check_ports("t6_cleared");
    check("t6_reg9", dataout[XLEN +: XLEN], 32'h0);
    @(posedge clock); #1;

    for (int n = 0; n < 400; n++) begin
      we0 = ($urandom_range(0, 2) != 0);
      we1 = ($urandom_range(0, 2) != 0);
      iss_valid = ($urandom_range(0, 2) == 0);
      rd0 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rd1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      iss_rd = AW'($urandom_range(0, 7));
      datain0 = $urandom;
      datain1 = $urandom;
      for (int p = 0; p < NREAD; p++)
        rs[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      #1 check_ports("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
